// File: rtl/afifo_16in_64out_512_pkg.sv
// Shared constants and pointer types for the 16-bit-in / 256-bit-out FIFO.
// Everything else in the FIFO derives its widths from here.
package afifo_16in_64out_512_pkg;

    localparam int WR_DEPTH_WIDTH = 11;
    localparam int WR_DATA_WIDTH  = 16;
    localparam int RD_DEPTH_WIDTH = 7;
    localparam int RD_DATA_WIDTH  = 256;
    localparam int RATIO_WIDTH    = WR_DEPTH_WIDTH - RD_DEPTH_WIDTH;
    localparam int RATIO          = 1 << RATIO_WIDTH;
    localparam int RD_DEPTH       = 1 << RD_DEPTH_WIDTH;

    // One extra wrap bit on each pointer separates full from empty.
    localparam int WR_PTR_WIDTH = WR_DEPTH_WIDTH + 1;
    localparam int RD_PTR_WIDTH = RD_DEPTH_WIDTH + 1;

    typedef logic [WR_PTR_WIDTH-1:0]   wr_ptr_t;
    typedef logic [RD_PTR_WIDTH-1:0]   rd_ptr_t;
    typedef logic [WR_DEPTH_WIDTH-1:0] wr_addr_t;
    typedef logic [RD_DEPTH_WIDTH-1:0] rd_addr_t;
    typedef logic [WR_DATA_WIDTH-1:0]  wr_word_t;
    typedef logic [RD_DATA_WIDTH-1:0]  rd_word_t;

    localparam wr_ptr_t WR_DEPTH_LEVEL   = wr_ptr_t'(1 << WR_DEPTH_WIDTH);
    localparam wr_ptr_t RATIO_LEVEL      = wr_ptr_t'(RATIO);
    localparam wr_ptr_t ALMOST_FULL_NUM  = wr_ptr_t'(2044);
    localparam rd_ptr_t ALMOST_EMPTY_NUM = rd_ptr_t'(4);

endpackage

// File: rtl/afifo_16in_64out_512_fifo_sdp_ram.sv
// Simple dual-port RAM: 2048x16 write port, 128x256 registered read port.
// Write address low bits select the 16-bit lane inside a 256-bit row.
import afifo_16in_64out_512_pkg::*;

module fifo_sdp_ram (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [WR_DEPTH_WIDTH-1:0] wr_addr,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    input  logic                      rd_en,
    input  logic [RD_DEPTH_WIDTH-1:0] rd_addr,
    output logic [RD_DATA_WIDTH-1:0]  rd_data
);

    rd_word_t mem [RD_DEPTH];

    logic [RD_DEPTH_WIDTH-1:0] wr_row;
    logic [7:0]                wr_lane_lsb;

    assign wr_row      = wr_addr[WR_DEPTH_WIDTH-1:RATIO_WIDTH];
    assign wr_lane_lsb = {wr_addr[RATIO_WIDTH-1:0], 4'b0000};

    // NOTE: the array has no reset so it maps onto block RAM; only the read
    // register is reset, and the pointers guarantee stale rows are never read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row][wr_lane_lsb +: WR_DATA_WIDTH] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/afifo_16in_64out_512.sv
// Width-converting single-clock FIFO: 16-bit writes packed into 256-bit reads.
// Holds pointers, occupancy arithmetic and registered status flags.
import afifo_16in_64out_512_pkg::*;

module afifo_16in_64out_512 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  wr_data,
    input  logic         wr_en,
    output logic         wr_full,
    output logic [11:0]  wr_water_level,
    output logic         almost_full,
    input  logic         rd_en,
    output logic [255:0] rd_data,
    output logic         rd_empty,
    output logic [7:0]   rd_water_level,
    output logic         almost_empty
);

    wr_ptr_t wr_ptr;
    rd_ptr_t rd_ptr;
    wr_ptr_t wr_ptr_nxt;
    rd_ptr_t rd_ptr_nxt;
    wr_ptr_t level_nxt;
    rd_ptr_t rd_level_nxt;
    logic    wr_accept;
    logic    rd_accept;

    assign wr_accept = wr_en && !wr_full;
    assign rd_accept = rd_en && !rd_empty;

    assign wr_ptr_nxt = wr_ptr + wr_ptr_t'(wr_accept);
    assign rd_ptr_nxt = rd_ptr + rd_ptr_t'(rd_accept);

    // One read word equals RATIO write words, so scale the read pointer up;
    // the modular difference never exceeds the 2048-word capacity.
    assign level_nxt    = wr_ptr_nxt - {rd_ptr_nxt, {RATIO_WIDTH{1'b0}}};
    assign rd_level_nxt = level_nxt[WR_PTR_WIDTH-1:RATIO_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            wr_water_level <= '0;
            wr_full        <= 1'b0;
            almost_full    <= 1'b0;
            rd_empty       <= 1'b1;
            almost_empty   <= 1'b1;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            wr_water_level <= level_nxt;
            wr_full        <= (level_nxt == WR_DEPTH_LEVEL);
            almost_full    <= (level_nxt >= ALMOST_FULL_NUM);
            rd_empty       <= (level_nxt < RATIO_LEVEL);
            almost_empty   <= (rd_level_nxt <= ALMOST_EMPTY_NUM);
        end
    end

    assign rd_water_level = wr_water_level[WR_PTR_WIDTH-1:RATIO_WIDTH];

    fifo_sdp_ram u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[WR_DEPTH_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr[RD_DEPTH_WIDTH-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_afifo_16in_64out_512.sv
// Self-checking bench for afifo_16in_64out_512 using a write-word scoreboard
// and an independent occupancy model.
module tb_afifo_16in_64out_512;

    logic         clk;
    logic         rst_n;
    logic [15:0]  wr_data;
    logic         wr_en;
    logic         wr_full;
    logic [11:0]  wr_water_level;
    logic         almost_full;
    logic         rd_en;
    logic [255:0] rd_data;
    logic         rd_empty;
    logic [7:0]   rd_water_level;
    logic         almost_empty;

    int           n_checks;
    int           n_errors;
    int           model_level;
    logic [15:0]  sb_q [$];
    logic [255:0] exp_rd_data;

    afifo_16in_64out_512 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one clock cycle and advances the model; outputs are sampled 1ns after the edge.
    task automatic drive(input logic wr, input logic [15:0] data, input logic rd);
        bit wr_acc;
        bit rd_acc;
        wr_en   = wr;
        wr_data = data;
        rd_en   = rd;
        wr_acc  = wr && (model_level < 2048);
        rd_acc  = rd && (model_level >= 16);
        if (rd_acc) begin
            for (int k = 0; k < 16; k++) begin
                exp_rd_data[16*k +: 16] = sb_q.pop_front();
            end
        end
        if (wr_acc) sb_q.push_back(data);
        model_level = model_level + int'(wr_acc) - 16 * int'(rd_acc);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (wr_full !== 1'b0 || almost_full !== 1'b0 || wr_water_level !== 12'd0 ||
            rd_water_level !== 8'd0 || rd_empty !== 1'b1 || almost_empty !== 1'b1 ||
            rd_data !== 256'd0) begin
            n_errors++;
            $display("FAIL reset_state: full=%b af=%b wl=%0d rwl=%0d empty=%b ae=%b data=%h, expected 0 0 0 0 1 1 0",
                     wr_full, almost_full, wr_water_level, rd_water_level, rd_empty, almost_empty, rd_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 2049; i++) begin
            drive(1'b1, 16'(16'hFFFF - i), 1'b0);
            n_checks++;
            if (wr_water_level !== 12'(model_level) || almost_full !== (model_level >= 2044) ||
                wr_full !== (model_level == 2048)) begin
                n_errors++;
                $display("FAIL fill_level write %0d: wl=%0d af=%b full=%b, expected wl=%0d af=%b full=%b",
                         i + 1, wr_water_level, almost_full, wr_full, model_level,
                         model_level >= 2044, model_level == 2048);
            end
        end
        n_checks++;
        if (wr_water_level !== 12'd2048 || rd_water_level !== 8'd128 || rd_empty !== 1'b0 ||
            wr_full !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_final: wl=%0d rwl=%0d empty=%b full=%b, expected 2048 128 0 1",
                     wr_water_level, rd_water_level, rd_empty, wr_full);
        end
    endtask

    task automatic test_drain();
        logic [255:0] first_word;
        for (int k = 0; k < 16; k++) first_word[16*k +: 16] = 16'(16'hFFFF - k);
        for (int i = 0; i < 129; i++) begin
            drive(1'b0, 16'h0000, 1'b1);
            n_checks++;
            if (rd_data !== exp_rd_data) begin
                n_errors++;
                $display("FAIL drain_data read %0d: got %h expected %h", i + 1, rd_data, exp_rd_data);
            end
            n_checks++;
            if (rd_water_level !== 8'(model_level / 16) || rd_empty !== (model_level < 16) ||
                almost_empty !== ((model_level / 16) <= 4)) begin
                n_errors++;
                $display("FAIL drain_status read %0d: rwl=%0d empty=%b ae=%b, expected %0d %b %b",
                         i + 1, rd_water_level, rd_empty, almost_empty, model_level / 16,
                         model_level < 16, (model_level / 16) <= 4);
            end
            if (i == 0) begin
                n_checks++;
                if (rd_data !== first_word) begin
                    n_errors++;
                    $display("FAIL drain_first_word: got %h expected %h", rd_data, first_word);
                end
            end
        end
        n_checks++;
        if (rd_empty !== 1'b1 || wr_water_level !== 12'd0) begin
            n_errors++;
            $display("FAIL drain_final: empty=%b wl=%0d, expected 1 0", rd_empty, wr_water_level);
        end
    endtask

    task automatic test_partial_group();
        for (int i = 0; i < 15; i++) drive(1'b1, 16'(16'h1000 + i), 1'b0);
        n_checks++;
        if (rd_empty !== 1'b1 || rd_water_level !== 8'd0 || wr_water_level !== 12'd15) begin
            n_errors++;
            $display("FAIL partial_15: empty=%b rwl=%0d wl=%0d, expected 1 0 15",
                     rd_empty, rd_water_level, wr_water_level);
        end
        drive(1'b1, 16'h100F, 1'b0);
        n_checks++;
        if (rd_empty !== 1'b0 || rd_water_level !== 8'd1 || wr_water_level !== 12'd16) begin
            n_errors++;
            $display("FAIL partial_16: empty=%b rwl=%0d wl=%0d, expected 0 1 16",
                     rd_empty, rd_water_level, wr_water_level);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] oldest;
        for (int k = 0; k < 16; k++) oldest[16*k +: 16] = 16'(16'h1000 + k);
        for (int i = 0; i < 16; i++) drive(1'b1, 16'(16'h2000 + i), 1'b0);
        drive(1'b1, 16'h3000, 1'b1);
        n_checks++;
        if (wr_water_level !== 12'd17 || rd_water_level !== 8'd1 || rd_data !== oldest) begin
            n_errors++;
            $display("FAIL simultaneous: wl=%0d rwl=%0d data=%h, expected 17 1 %h",
                     wr_water_level, rd_water_level, rd_data, oldest);
        end
        n_checks++;
        if (exp_rd_data !== rd_data) begin
            n_errors++;
            $display("FAIL simultaneous_sb: got %h expected %h", rd_data, exp_rd_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] exp_word;
        while (model_level < 1000) drive(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
        n_checks++;
        if (wr_water_level !== 12'd1000) begin
            n_errors++;
            $display("FAIL mid_level: wl=%0d expected 1000", wr_water_level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (wr_full !== 1'b0 || almost_full !== 1'b0 || wr_water_level !== 12'd0 ||
            rd_water_level !== 8'd0 || rd_empty !== 1'b1 || almost_empty !== 1'b1 ||
            rd_data !== 256'd0) begin
            n_errors++;
            $display("FAIL mid_reset_async: wl=%0d rwl=%0d empty=%b ae=%b data=%h, expected 0 0 1 1 0",
                     wr_water_level, rd_water_level, rd_empty, almost_empty, rd_data);
        end
        sb_q.delete();
        model_level = 0;
        exp_rd_data = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, 16'(16'hA5A0 + i), 1'b0);
        drive(1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 16; k++) exp_word[16*k +: 16] = 16'(16'hA5A0 + k);
        n_checks++;
        if (rd_data[15:0] !== 16'hA5A0 || rd_data !== exp_word || rd_data !== exp_rd_data) begin
            n_errors++;
            $display("FAIL post_reset_read: got %h expected %h", rd_data, exp_word);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        model_level = 0;
        exp_rd_data = '0;
        rst_n       = 1'b1;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        wr_data     = 16'h0000;
        #2;
        test_reset();
        test_fill();
        test_drain();
        test_partial_group();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
